// File: rtl/adc_serial_rx_multi.sv
// -----------------------------------------------------------------------------
// adc_serial_rx_multi
//
// Frame receiver for N_CH simultaneously sampled serial ADCs that share one
// chip select and one serial clock. The block drives CS low for one frame of
// FRAME_BITS serial clocks and shifts one bit per channel, MSB first, on every
// rising edge of sclk. When the last bit of the frame arrives it raises CS,
// presents the low DATA_BITS of each channel's frame on Dato and pulses valid
// for one cycle. CS then stays high for at least QUIET_CYC cycles. After that
// the block either starts the next frame (cont=1) or returns to idle.
//
// Optional build macro: ADC_ZERO_CHECK_EN
//   defined     : zero_err[i] is set at each valid when any of the leading
//                 FRAME_BITS-DATA_BITS bits of channel i's frame is nonzero.
//   not defined : zero_err is tied to 0 and no check logic is built.
//
// Ports
//   Clock_Muestreo  in   sampling/system clock, rising edge
//   reset           in   asynchronous reset, active low
//   start           in   single conversion request, looked at only in idle
//   cont            in   continuous mode, chains frames after the quiet gap
//   sdata[N_CH]     in   serial data, bit i = channel i, MSB first
//   CS              out  ADC chip select, active low, registered
//   sclk            out  ADC serial clock, registered, idles high
//   busy            out  high from CS fall until the quiet gap ends
//   valid           out  one-cycle strobe, Dato updated this cycle
//   Dato            out  results, channel i at [i*DATA_BITS +: DATA_BITS]
//   zero_err[N_CH]  out  per-channel leading-bit error flag
// -----------------------------------------------------------------------------
module adc_serial_rx_multi #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int N_CH       = 2,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 2
) (
  input  logic                      Clock_Muestreo,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cont,
  input  logic [N_CH-1:0]           sdata,
  output logic                      CS,
  output logic                      sclk,
  output logic                      busy,
  output logic                      valid,
  output logic [N_CH*DATA_BITS-1:0] Dato,
  output logic [N_CH-1:0]           zero_err
);

  // Half period of sclk in clock cycles.
  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int Q_W   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_QUIET = 2'd2
  } state_t;

  state_t                            state_q;
  logic [DIV_W-1:0]                  div_q;
  logic [BIT_W-1:0]                  bitcnt_q;
  logic [Q_W-1:0]                    qcnt_q;
  logic [N_CH-1:0][FRAME_BITS-1:0]   shreg_q;
  logic [N_CH-1:0][FRAME_BITS-1:0]   shreg_d;
  logic                              cs_q;
  logic                              sclk_q;
  logic                              busy_q;
  logic                              valid_q;
  logic [N_CH*DATA_BITS-1:0]         dato_q;

  logic                              frame_go_s;
  logic                              qdone_s;
  logic                              sclk_edge_s;
  logic                              last_bit_s;

`ifdef ADC_ZERO_CHECK_EN
  logic [N_CH-1:0]                   zerr_q;

  // True when any bit above the kept result field is set.
  function automatic logic lead_nonzero(input logic [FRAME_BITS-1:0] frame);
    logic [FRAME_BITS-1:0] upper;
    upper = frame >> DATA_BITS;
    return (upper != '0);
  endfunction
`endif

  // Control decode: quiet-gap end, sclk half-period end, last frame bit, frame launch.
  always_comb begin
    qdone_s     = (qcnt_q == Q_W'(QUIET_CYC - 1));
    sclk_edge_s = (div_q == DIV_W'(HALF - 1));
    last_bit_s  = (bitcnt_q == BIT_W'(FRAME_BITS - 1));
    frame_go_s  = 1'b0;
    case (state_q)
      ST_IDLE:  frame_go_s = start | cont;
      // Continuous mode chains straight into the next frame once the gap is served.
      ST_QUIET: frame_go_s = qdone_s & cont;
      default:  frame_go_s = 1'b0;
    endcase
  end

  // Next shift-register contents: new serial bit enters at the LSB.
  always_comb begin
    shreg_d = shreg_q;
    for (int i = 0; i < N_CH; i++) begin
      shreg_d[i] = {shreg_q[i][FRAME_BITS-2:0], sdata[i]};
    end
  end

  // Frame sequencer with registered CS/sclk/busy/valid/Dato.
  always_ff @(posedge Clock_Muestreo or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      qcnt_q   <= '0;
      shreg_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dato_q   <= '0;
`ifdef ADC_ZERO_CHECK_EN
      zerr_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (frame_go_s) begin
        // Frame launch edge: CS falls, sclk stays high for its first half period.
        state_q  <= ST_CONV;
        cs_q     <= 1'b0;
        sclk_q   <= 1'b1;
        busy_q   <= 1'b1;
        div_q    <= '0;
        bitcnt_q <= '0;
        qcnt_q   <= '0;
        shreg_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            busy_q <= 1'b0;
          end
          ST_CONV: begin
            if (sclk_edge_s) begin
              div_q  <= '0;
              sclk_q <= ~sclk_q;
              // sclk going 0->1 on this edge: capture one bit per channel.
              if (!sclk_q) begin
                shreg_q  <= shreg_d;
                bitcnt_q <= bitcnt_q + BIT_W'(1);
                if (last_bit_s) begin
                  cs_q    <= 1'b1;
                  valid_q <= 1'b1;
                  qcnt_q  <= '0;
                  state_q <= ST_QUIET;
                  for (int i = 0; i < N_CH; i++) begin
                    dato_q[i*DATA_BITS +: DATA_BITS] <= shreg_d[i][DATA_BITS-1:0];
`ifdef ADC_ZERO_CHECK_EN
                    zerr_q[i] <= lead_nonzero(shreg_d[i]);
`endif
                  end
                end else begin
                  cs_q <= 1'b0;
                end
              end else begin
                cs_q <= 1'b0;
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          ST_QUIET: begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            if (qdone_s) begin
              // Gap served and no chained frame: drop busy and go idle.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              qcnt_q <= qcnt_q + Q_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign CS    = cs_q;
  assign sclk  = sclk_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign Dato  = dato_q;

`ifdef ADC_ZERO_CHECK_EN
  assign zero_err = zerr_q;
`else
  assign zero_err = '0;
`endif

endmodule

// File: doc/adc_serial_rx_multi.md
Name: adc_serial_rx_multi

Overview:
Parametrised multi-channel serial ADC frame receiver. It generates chip-select and serial clock for N_CH simultaneously sampled serial ADCs that share CS and SCLK (for example, the dual 12-bit device on the sampling board). It shifts in one FRAME_BITS-long frame per channel and presents the DATA_BITS LSBs of each frame with a one-cycle valid strobe. It supports single-shot and continuous conversion and sits between the sampling clock domain and the downstream processing/display logic.

Parameters:
FRAME_BITS, 16, serial bits per conversion frame (CS low window); must be ≥ DATA_BITS.
DATA_BITS, 12, result bits kept per channel (last DATA_BITS bits of the frame).
N_CH, 2, number of parallel serial data lines.
CLK_DIV, 4, Clock_Muestreo cycles per SCLK period; even, ≥ 2.
QUIET_CYC, 2, minimum cycles CS stays high between frames; ≥ 1.

Ports:
Clock_Muestreo  in  1  single system/sampling clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  request one conversion; sampled only in IDLE.
cont  in  1  continuous mode; while 1, a new frame starts automatically after QUIET.
sdata  in  N_CH  serial data from the ADCs, bit i = channel i, MSB first.
CS  out  1  ADC chip select, active low, registered.
sclk  out  1  ADC serial clock, registered, idles high.
busy  out  1  1 from CS fall until the QUIET phase ends.
valid  out  1  one-cycle strobe: Dato updated this cycle.
Dato  out  N_CH*DATA_BITS  results; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
zero_err  out  N_CH  per-channel leading-bit error flag (see Optional Feature).

Behaviour:
- Reset (reset=0, async): CS=1, sclk=1, busy=0, valid=0, Dato=0, zero_err=0, state IDLE, counters 0. Reset mid-frame aborts immediately with no valid pulse.
- States: IDLE, CONV, QUIET.
- IDLE: CS=1, sclk=1, busy=0. Edge E0 with (start|cont)=1 -> CONV; at E0 CS<=0, busy<=1, div=0, bitcnt=0, shift regs cleared.
- CONV: H=CLK_DIV/2. div counts 0..H-1; on the edge where div=H-1, sclk toggles and div<=0. First sclk fall occurs H cycles after E0.
- Sampling: on each edge where sclk goes 0->1, shift sdata[i] into the LSB of shreg[i] (MSB-first frame) and increment bitcnt.
- On the edge capturing bit FRAME_BITS (E0 + FRAME_BITS*CLK_DIV): CS<=1, sclk stays 1, Dato[ch i]<=low DATA_BITS of the completed shreg[i], valid<=1 for exactly one cycle, state -> QUIET.
- Latency: start sampled at E0 -> valid high in cycle E0+FRAME_BITS*CLK_DIV (64 cycles at defaults).
- QUIET: CS=1 for QUIET_CYC cycles, busy=1. Then: if cont=1, go directly to CONV (CS falls on that edge, identical to E0). Otherwise go to IDLE with busy<=0.
- start while busy is ignored, not queued. cont deasserted mid-frame: the current frame completes normally, then the block returns to IDLE.
- Dato holds its last value until the next valid. It never changes without valid.
- Bits above DATA_BITS in the frame are discarded, except as checked by the Optional Feature.

Optional Feature:
ADC_ZERO_CHECK_EN
- Defined: at the valid edge, zero_err[i]<=1 if any of the leading FRAME_BITS-DATA_BITS bits of channel i's frame is nonzero, else 0. zero_err updates only with valid. Dato is still updated.
- Not defined: zero_err is tied to 0 and no check logic is built.

Test Plan:
1. Defaults; reset released; start pulse; ch0 model sends 0x0ABC, ch1 sends 0x0123 -> CS low 64 cycles, 16 sclk rising edges, valid for 1 cycle at E0+64, Dato=24'h123ABC, busy low after 2 quiet cycles.
2. cont=1 held, models send 0x0111/0x0222 then 0x0333/0x0444 -> CS high exactly QUIET_CYC=2 cycles between frames; successive Dato 24'h222111, then 24'h444333.
3. start pulsed again at cycle E0+10 while busy -> no extra frame; exactly one valid pulse.
4. reset driven low at E0+30 -> CS=1, sclk=1, busy=0 asynchronously; no valid; Dato=0. Next start gives a clean full frame.
5. ADC_ZERO_CHECK_EN defined; ch1 frame 0x8123, ch0 0x0ABC -> Dato=24'h123ABC, zero_err=2'b10. Without the macro -> zero_err=0.
6. FRAME_BITS=14, DATA_BITS=12, N_CH=1, CLK_DIV=2; frame 14'h0FFF -> valid at E0+28, Dato=12'hFFF.
